// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold / shift right / shift left / load,
// with serial I/O at both ends and a saturating shift counter. `USR_ROTATE_EN turns shifts into rotates.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  output logic [WIDTH-1:0] q,
  output logic             sout_lsb,
  output logic             sout_msb,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    cnt_inc;
  logic             done_next;
  logic             fill_msb;
  logic             fill_lsb;

  // Bits entering the vacated end on a shift: serial inputs, or the wrapped-around bit when rotating.
`ifdef USR_ROTATE_EN
  logic unused_sin;
  assign unused_sin = sin_msb ^ sin_lsb;
  assign fill_msb   = q[0];
  assign fill_lsb   = q[WIDTH-1];
`else
  assign fill_msb   = sin_msb;
  assign fill_lsb   = sin_lsb;
`endif

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  always_comb begin
    q_next    = q;
    cnt_next  = cnt;
    done_next = done;
    if (en) begin
      case (mode)
        MODE_HOLD: ;
        MODE_RIGHT: begin
          q_next    = {fill_msb, q[WIDTH-1:1]};
          cnt_next  = cnt_inc;
          done_next = (cnt_inc == CNT_MAX);
        end
        MODE_LEFT: begin
          q_next    = {q[WIDTH-2:0], fill_lsb};
          cnt_next  = cnt_inc;
          done_next = (cnt_inc == CNT_MAX);
        end
        MODE_LOAD: begin
          q_next    = d;
          cnt_next  = '0;
          done_next = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q    <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      q    <= q_next;
      cnt  <= cnt_next;
      done <= done_next;
    end
  end

  assign sout_lsb = q[0];
  assign sout_msb = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=4): directed test-plan sequences then random traffic,
// checked against an arithmetic reference model.
module tb_univ_shift_reg;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(W + 1);
  localparam int MASK = (1 << W) - 1;

  typedef struct {
    logic [W-1:0]  q;
    logic [CW-1:0] cnt;
    logic          done;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [1:0]    mode;
  logic [W-1:0]  d;
  logic          sin_msb;
  logic          sin_lsb;
  logic [W-1:0]  q;
  logic          sout_lsb;
  logic          sout_msb;
  logic [CW-1:0] cnt;
  logic          done;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   m_q    = 0;
  int   m_cnt  = 0;
  int   m_done = 0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q),
    .sout_lsb(sout_lsb), .sout_msb(sout_msb), .cnt(cnt), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Drive one cycle of inputs, advance the reference model, queue the expected result.
  task automatic step(input bit r, input bit e, input int md, input int dv, input bit sm, input bit sl);
    int fill;
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; mode = 2'(md); d = W'(dv); sin_msb = sm; sin_lsb = sl;
    if (!r) begin
      m_q = 0; m_cnt = 0; m_done = 0;
    end else if (e) begin
      if (md == 1 || md == 2) begin
        if (md == 1) begin
`ifdef USR_ROTATE_EN
          fill = m_q % 2;
`else
          fill = int'(sm);
`endif
          m_q = (m_q / 2) + fill * (1 << (W - 1));
        end else begin
`ifdef USR_ROTATE_EN
          fill = m_q / (1 << (W - 1));
`else
          fill = int'(sl);
`endif
          m_q = (m_q * 2 + fill) & MASK;
        end
        if (m_cnt < W) m_cnt++;
        m_done = (m_cnt == W) ? 1 : 0;
      end else if (md == 3) begin
        m_q = dv & MASK; m_cnt = 0; m_done = 0;
      end
    end
    x.q = W'(m_q); x.cnt = CW'(m_cnt); x.done = (m_done != 0);
    exp_q.push_back(x);
  endtask

  // Monitor: every edge yields a result; compare it against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("q",        int'(q),        int'(e.q));
        check("cnt",      int'(cnt),      int'(e.cnt));
        check("done",     int'(done),     int'(e.done));
        check("sout_lsb", int'(sout_lsb), int'(e.q[0]));
        check("sout_msb", int'(sout_msb), int'(e.q[W-1]));
      end
    end
  end

  initial begin
    int budget;
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; d = '0; sin_msb = 1'b0; sin_lsb = 1'b0;

    // Reset priority over a load, then the load takes effect.
    step(0, 1, 3, 4'b1001, 0, 0);
    step(1, 1, 3, 4'b1001, 0, 0);
    // Hold mode and clock-enable gating.
    step(1, 1, 3, 4'b1011, 0, 0);
    repeat (3) step(1, 1, 0, 0, 1, 1);
    repeat (2) step(1, 0, 3, 4'b1111, 1, 1);
    // PISO right shift past saturation.
    step(1, 1, 3, 4'b1011, 0, 0);
    repeat (5) step(1, 1, 1, 0, 0, 1);
    // SIPO left shift from reset, then load clears the counter.
    step(0, 1, 0, 0, 0, 0);
    repeat (4) step(1, 1, 2, 0, 0, 1);
    step(1, 1, 3, 4'b0000, 0, 0);
    // Single left shift of 1001 (rotate vs shift).
    step(1, 1, 3, 4'b1001, 0, 0);
    step(1, 1, 2, 0, 0, 0);
    // Reset in the middle of a shift sequence.
    step(1, 1, 3, 4'b1111, 0, 0);
    repeat (2) step(1, 1, 1, 0, 1, 0);
    step(0, 1, 1, 0, 1, 0);
    // Load on the edge that would have set done.
    step(1, 1, 3, 4'b0110, 0, 0);
    repeat (3) step(1, 1, 2, 0, 1, 0);
    step(1, 1, 3, 4'b1100, 0, 0);

    // Random traffic: occasional reset, mostly enabled, shift-heavy to reach saturation.
    for (int i = 0; i < 400; i++) begin
      int md;
      md = ($urandom_range(0, 9) < 6) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 3));
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), md,
           int'($urandom_range(0, MASK)), 1'($urandom), 1'($urandom));
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
